// File: rtl/br_redirect_ctl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | br_redirect_ctl_pkg : shared types for the mispredict/redirect path   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package br_redirect_ctl_pkg;

    localparam int unsigned PKG_ROB_IDX_W = 5;
    localparam int unsigned PADDR_W       = 32;

    typedef logic [PADDR_W-1:0] t_paddr;

    typedef struct packed {
        logic                     wrap;
        logic [PKG_ROB_IDX_W-1:0] idx;
    } t_rob_id;

    typedef struct packed {
        logic    valid;
        t_paddr  target_addr;
        t_rob_id robid;
    } t_br_mispred_pkt;

    typedef struct packed {
        logic   valid;
        t_paddr addr;
    } t_fe_redirect_pkt;

    typedef enum logic [1:0] {
        RC_IDLE     = 2'd0,
        RC_FLUSH    = 2'd1,
        RC_DRAIN    = 2'd2,
        RC_REDIRECT = 2'd3
    } t_redirect_ctl_state;

    // Wrap bits differ once the ROB pointer has lapped, which inverts the index order.
    function automatic logic rob_older(input t_rob_id a, input t_rob_id b);
        return (a.wrap == b.wrap) ? (a.idx < b.idx) : (a.idx > b.idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/br_oldest_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | br_oldest_sel : combinational NUM_BR-way oldest-robid selection       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module br_oldest_sel
    import br_redirect_ctl_pkg::*;
#(
    parameter int unsigned NUM_BR = 2
) (
    input  t_br_mispred_pkt [NUM_BR-1:0] i_pkts,
    output t_br_mispred_pkt              o_sel
);

    t_br_mispred_pkt w_best;

    // Only a strictly older packet displaces the current pick, so ties keep the lowest unit.
    always_comb begin
        w_best = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            if (i_pkts[i].valid && (!w_best.valid || rob_older(i_pkts[i].robid, w_best.robid))) begin
                w_best = i_pkts[i];
            end
        end
    end

    assign o_sel = w_best;

endmodule
`default_nettype wire

// File: rtl/br_redirect_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | br_redirect_ctl : oldest-mispredict flush, drain and fetch redirect   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module br_redirect_ctl
    import br_redirect_ctl_pkg::*;
#(
    parameter int unsigned NUM_BR    = 2,
    parameter int unsigned ROB_IDX_W = PKG_ROB_IDX_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  t_br_mispred_pkt [NUM_BR-1:0] br_mispred_ex0,
    input  logic                         drain_done,
    input  logic                         fe_redirect_ready,
    output logic                         flush_valid,
    output logic [ROB_IDX_W:0]           flush_robid,
    output logic                         fe_redirect_valid,
    output t_paddr                       fe_redirect_addr,
    output logic                         busy,
    output logic [31:0]                  mispred_cnt
);

    t_redirect_ctl_state state_q, state_d;
    t_rob_id             cap_robid_q, cap_robid_d;
    t_paddr              cap_tgt_q, cap_tgt_d;
    logic                flush_valid_q, flush_valid_d;
    t_rob_id             flush_robid_q, flush_robid_d;
    t_fe_redirect_pkt    fe_redirect_q, fe_redirect_d;
    logic                busy_q, busy_d;
    logic [31:0]         mispred_cnt_q, mispred_cnt_d;

    t_br_mispred_pkt     sel;
    logic                take_new;

    br_oldest_sel #(
        .NUM_BR (NUM_BR)
    ) u_oldest_sel (
        .i_pkts (br_mispred_ex0),
        .o_sel  (sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RC_IDLE;
            cap_robid_q   <= '0;
            cap_tgt_q     <= '0;
            flush_valid_q <= 1'b0;
            flush_robid_q <= '0;
            fe_redirect_q <= '0;
            busy_q        <= 1'b0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            cap_robid_q   <= cap_robid_d;
            cap_tgt_q     <= cap_tgt_d;
            flush_valid_q <= flush_valid_d;
            flush_robid_q <= flush_robid_d;
            fe_redirect_q <= fe_redirect_d;
            busy_q        <= busy_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // An older arrival overrides every other transition, including a same-cycle
    // drain_done or redirect handshake; the accepted redirect still stands.
    always_comb begin
        state_d     = state_q;
        cap_robid_d = cap_robid_q;
        cap_tgt_d   = cap_tgt_q;
        take_new    = sel.valid && ((state_q == RC_IDLE) || rob_older(sel.robid, cap_robid_q));
        if (take_new) begin
            state_d     = RC_FLUSH;
            cap_robid_d = sel.robid;
            cap_tgt_d   = sel.target_addr;
        end else begin
            case (state_q)
                RC_FLUSH:    state_d = RC_DRAIN;
                RC_DRAIN:    if (drain_done)        state_d = RC_REDIRECT;
                RC_REDIRECT: if (fe_redirect_ready) state_d = RC_IDLE;
                default:     state_d = state_q;
            endcase
        end
    end

    // Outputs are decoded from the next state so they appear registered with no extra latency.
    always_comb begin
        flush_valid_d       = (state_d == RC_FLUSH);
        flush_robid_d       = flush_valid_d ? cap_robid_d : flush_robid_q;
        fe_redirect_d.valid = (state_d == RC_REDIRECT);
        fe_redirect_d.addr  = fe_redirect_d.valid ? cap_tgt_d : fe_redirect_q.addr;
        busy_d              = (state_d != RC_IDLE);
        mispred_cnt_d       = mispred_cnt_q;
        if (flush_valid_d && !(&mispred_cnt_q)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    assign flush_valid       = flush_valid_q;
    assign flush_robid       = flush_robid_q;
    assign fe_redirect_valid = fe_redirect_q.valid;
    assign fe_redirect_addr  = fe_redirect_q.addr;
    assign busy              = busy_q;
    assign mispred_cnt       = mispred_cnt_q;

endmodule
`default_nettype wire
